// File: rtl/load_unit_pkg.sv
// Shared processor definitions: load_control encodings, load-unit FSM
// states and the misalignment predicate used by the load stage.
package load_unit_pkg;

    // load_control encodings (RISC-V funct3 of the LOAD opcode)
    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_WB
    } lu_state_e;

    // Unknown encodings behave as LW, so they need full word alignment.
    function automatic logic misaligned(
        input logic [2:0] ctrl,
        input logic [1:0] off
    );
        case (ctrl)
            LS_LB, LS_LBU: misaligned = 1'b0;
            LS_LH, LS_LHU: misaligned = off[0];
            default:       misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_unit_align_ext.sv
// load_align_ext: combinational lane extraction and sign/zero extension.
// Ports: word_i (little-endian word), off_i (ea[1:0]), ctrl_i, data_o.
module load_align_ext
    import load_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      ctrl_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        unique case (off_i)
            2'd0: byte_s = word_i[7:0];
            2'd1: byte_s = word_i[15:8];
            2'd2: byte_s = word_i[23:16];
            2'd3: byte_s = word_i[31:24];
        endcase
        half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (ctrl_i)
            LS_LB:   data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            LS_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_s};
            LS_LH:   data_o = {{(XLEN-16){half_s[15]}}, half_s};
            LS_LHU:  data_o = {{(XLEN-16){1'b0}}, half_s};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: one-at-a-time load stage. Accepts decoded load (rs1_data,
// imm, rd, load_control) on in_valid/in_ready, issues a word read on
// mem_req_*, waits on mem_rsp_*, and writes back via wb_* for one cycle.
// misalign_err qualifies wb_valid; flush squashes the in-flight load.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [11:0]       imm,
    input  logic [4:0]        rd,
    input  logic [2:0]        load_control,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misalign_err
);

    lu_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        ctrl_q;
    logic [4:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;
    logic              err_q;

    logic [ADDR_W-1:0] ea_d;
    logic              mis_d;
    logic [XLEN-1:0]   ext_d;

    always_comb begin
        ea_d  = rs1_data[ADDR_W-1:0]
              + {{(ADDR_W-12){imm[11]}}, imm};
        mis_d = misaligned(load_control, ea_d[1:0]);
    end

    load_align_ext #(
        .XLEN (XLEN)
    ) u_align (
        .word_i (mem_rsp_data),
        .off_i  (off_q),
        .ctrl_i (ctrl_q),
        .data_o (ext_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            off_q     <= 2'b00;
            ctrl_q    <= 3'b000;
            wb_rd_q   <= 5'd0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // flush in IDLE only blocks this cycle's accept
                    if (in_valid && !flush) begin
                        addr_q    <= {ea_d[ADDR_W-1:2], 2'b00};
                        off_q     <= ea_d[1:0];
                        ctrl_q    <= load_control;
                        wb_rd_q   <= rd;
                        wb_data_q <= '0;
                        err_q     <= mis_d;
                        state_q   <= mis_d ? ST_WB : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush)
                        state_q <= ST_IDLE;
                    else if (mem_req_ready)
                        state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // a response coinciding with flush is already the
                    // one we would drain, so drop it and go idle
                    if (mem_rsp_valid) begin
                        if (flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            wb_data_q <= ext_d;
                            state_q   <= ST_WB;
                        end
                    end else if (flush) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_rsp_valid)
                        state_q <= ST_IDLE;
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = addr_q;
    assign wb_valid      = (state_q == ST_WB);
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign misalign_err  = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit.
// Word at 0x1004 is 0x80FF7F01; expected values are hand-computed.
module tb_load_unit;
    import load_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [2:0]  load_control;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] WORD = 32'h80FF7F01;

    always #5 clk = ~clk;

    load_unit dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs1_data      (rs1_data),
        .imm           (imm),
        .rd            (rd),
        .load_control  (load_control),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .misalign_err  (misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_accept(input logic [31:0] r1, input logic [11:0] im,
                                input logic [2:0] lc, input logic [4:0] d);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid     = 1'b1;
        rs1_data     = r1;
        imm          = im;
        load_control = lc;
        rd           = d;
    endtask

    // Aligned load: accept at N, REQ for 1+stall cycles, WAIT one idle
    // cycle, response, then writeback expected one cycle later.
    task automatic do_load(input string tag, input logic [31:0] r1,
                           input logic [11:0] im, input logic [2:0] lc,
                           input logic [4:0] d, input int stall,
                           input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        drive_accept(r1, im, lc, d);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_req_hold"}, {31'd0, mem_req_valid}, 32'd1);
            chk({tag, "_addr_hold"}, mem_addr, exp_addr);
            chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
            step();
        end
        chk({tag, "_req"}, {31'd0, mem_req_valid}, 32'd1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk({tag, "_req_drop"}, {31'd0, mem_req_valid}, 32'd0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = WORD;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_data"}, wb_data, exp_data);
        chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, d});
        chk({tag, "_err"}, {31'd0, misalign_err}, 32'd0);
        step();
        chk({tag, "_wb_once"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        rs1_data      = 32'h0;
        imm           = 12'h0;
        rd            = 5'd0;
        load_control  = LS_LW;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;
        step();

        do_load("lb_b0", 32'h1000, 12'h004, LS_LB, 5'd1, 0,
                32'h1004, 32'h00000001);
        do_load("lb_b3", 32'h100B, 12'hFFC, LS_LB, 5'd2, 0,
                32'h1004, 32'hFFFFFF80);
        do_load("lbu_b3", 32'h100B, 12'hFFC, LS_LBU, 5'd3, 0,
                32'h1004, 32'h00000080);
        do_load("lh_hi", 32'h1000, 12'h006, LS_LH, 5'd4, 0,
                32'h1004, 32'hFFFF80FF);
        do_load("lhu_hi", 32'h1000, 12'h006, LS_LHU, 5'd6, 0,
                32'h1004, 32'h000080FF);
        do_load("lw", 32'h1000, 12'h004, LS_LW, 5'd5, 0,
                32'h1004, 32'h80FF7F01);
        do_load("lbu_b1", 32'h1000, 12'h005, LS_LBU, 5'd0, 0,
                32'h1004, 32'h0000007F);

        // misaligned LW: trap at accept+1, no memory request
        drive_accept(32'h1000, 12'h002, LS_LW, 5'd7);
        step();
        in_valid = 1'b0;
        chk("mis_wbv", {31'd0, wb_valid}, 32'd1);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_data", wb_data, 32'h0);
        chk("mis_rd", {27'd0, wb_rd}, 32'd7);
        chk("mis_noreq", {31'd0, mem_req_valid}, 32'd0);
        step();
        chk("mis_noreq2", {31'd0, mem_req_valid}, 32'd0);
        chk("mis_wb_once", {31'd0, wb_valid}, 32'd0);

        // request backpressure for 3 cycles
        do_load("bp_lw", 32'h1000, 12'h004, LS_LW, 5'd9, 3,
                32'h1004, 32'h80FF7F01);

        // flush while in WAIT, late response drained
        drive_accept(32'h1000, 12'h004, LS_LW, 5'd10);
        step();
        in_valid = 1'b0;
        chk("fl_req", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_nowb0", {31'd0, wb_valid}, 32'd0);
        chk("fl_drain_busy", {31'd0, in_ready}, 32'd0);
        step();
        chk("fl_nowb1", {31'd0, wb_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        chk("fl_nowb2", {31'd0, wb_valid}, 32'd0);
        chk("fl_idle", {31'd0, in_ready}, 32'd1);
        step();
        chk("fl_nowb3", {31'd0, wb_valid}, 32'd0);
        do_load("post_fl", 32'h1000, 12'h004, LS_LW, 5'd11, 0,
                32'h1004, 32'h80FF7F01);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
